// File: rtl/crypt_pkg.sv
// Shared types and default sizing for the crypt sequencer block.
package crypt_pkg;

  localparam int DEF_MSG_SIZE = 64;
  localparam int DEF_KEY_SIZE = 8;

  // Encodings are visible on state_dbg, so they are pinned explicitly.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_KEY = 3'd1,
    S_LOAD_MSG = 3'd2,
    S_ENCRYPT  = 3'd3,
    S_SEND     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/crypt_sequencer_if.sv
// Serial key/message input stream and serial ciphertext output stream.
interface crypt_sequencer_if;
  logic sin;
  logic sin_valid;
  logic sin_ready;
  logic sout;
  logic sout_valid;
  logic sout_ready;

  modport slave (
    input  sin, sin_valid, sout_ready,
    output sin_ready, sout, sout_valid
  );

  modport master (
    output sin, sin_valid, sout_ready,
    input  sin_ready, sout, sout_valid
  );
endinterface

// File: rtl/crypt_bit_counter.sv
// Bit counter with clear, increment and a terminal-count flag.
// "last" is high while the count sits on the final position (term-1), so
// the caller can combine it with its transfer strobe to detect completion.
module crypt_bit_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         last
);

  logic [W-1:0] count;

  // Clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + 1'b1;
  end

  assign last = (count == term - 1'b1);

endmodule

// File: rtl/crypt_sequencer.sv
// Serial XOR-with-repeating-key sequencer: load key, load message,
// encrypt in one cycle, then stream the ciphertext out MSB first.
module crypt_sequencer
  import crypt_pkg::*;
#(
  parameter int MSG_SIZE = DEF_MSG_SIZE,
  parameter int KEY_SIZE = DEF_KEY_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                start,
  input  logic                abort,
  crypt_sequencer_if.slave    sio,
  output logic                busy,
  output logic                done,
  output logic [2:0]          state_dbg
);

  localparam int CW   = $clog2(MSG_SIZE) + 1;
  localparam int REPS = MSG_SIZE / KEY_SIZE;
  localparam logic [CW-1:0] KEY_TERM = CW'(KEY_SIZE);
  localparam logic [CW-1:0] MSG_TERM = CW'(MSG_SIZE);

  state_t state, state_nxt;

  logic [KEY_SIZE-1:0] key_q;
  logic [MSG_SIZE-1:0] msg_q;
  logic [MSG_SIZE-1:0] ct_q;

  logic          sin_fire, sout_fire;
  logic          in_last, out_last;
  logic          in_clr, in_inc, out_clr, out_inc;
  logic [CW-1:0] in_term;

  // Handshake outputs; ena low drops both ready/valid so nothing moves.
  assign sio.sin_ready  = ena & ((state == S_LOAD_KEY) | (state == S_LOAD_MSG));
  assign sio.sout_valid = ena & (state == S_SEND);
  assign sio.sout       = (state == S_SEND) & ct_q[MSG_SIZE-1];

  // Abort outranks any transfer in the same cycle.
  assign sin_fire  = sio.sin_ready  & sio.sin_valid  & ~abort;
  assign sout_fire = sio.sout_valid & sio.sout_ready & ~abort;

  assign busy      = (state != S_IDLE);
  assign done      = ena & (state == S_DONE);
  assign state_dbg = state;

  // One input counter serves both load phases; it restarts between them.
  assign in_term = (state == S_LOAD_KEY) ? KEY_TERM : MSG_TERM;
  assign in_clr  = ena & ((state == S_IDLE) | abort |
                          ((state == S_LOAD_KEY) & sin_fire & in_last));
  assign in_inc  = sin_fire;
  assign out_clr = ena & ((state != S_SEND) | abort);
  assign out_inc = sout_fire;

  crypt_bit_counter #(.W(CW)) u_in_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (in_clr),
    .inc   (in_inc),
    .term  (in_term),
    .last  (in_last)
  );

  crypt_bit_counter #(.W(CW)) u_out_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (out_clr),
    .inc   (out_inc),
    .term  (MSG_TERM),
    .last  (out_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= S_IDLE;
    else if (ena) state <= state_nxt;
  end

  // Next-state logic; start+abort together in IDLE stays put.
  always_comb begin
    state_nxt = state;
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:     if (start && !abort)      state_nxt = S_LOAD_KEY;
        S_LOAD_KEY: if (sin_fire && in_last)  state_nxt = S_LOAD_MSG;
        S_LOAD_MSG: if (sin_fire && in_last)  state_nxt = S_ENCRYPT;
        S_ENCRYPT:                            state_nxt = S_SEND;
        S_SEND:     if (sout_fire && out_last) state_nxt = S_DONE;
        S_DONE:                               state_nxt = S_IDLE;
        default:                              state_nxt = S_IDLE;
      endcase
    end
  end

  // Key/message shift-in, one-shot encrypt, ciphertext shift-out.
  // Key and message only change on accepted input bits, so they survive
  // past DONE until the next session overwrites them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
      msg_q <= '0;
      ct_q  <= '0;
    end else if (ena && !abort) begin
      if (sin_fire && (state == S_LOAD_KEY))
        key_q <= {key_q[KEY_SIZE-2:0], sio.sin};
      if (sin_fire && (state == S_LOAD_MSG))
        msg_q <= {msg_q[MSG_SIZE-2:0], sio.sin};
      if (state == S_ENCRYPT)
        ct_q <= msg_q ^ {REPS{key_q}};
      else if (sout_fire)
        ct_q <= {ct_q[MSG_SIZE-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_crypt_sequencer.sv
// Directed bench for crypt_sequencer: sessions, stalls, abort, enable, reset.
module tb_crypt_sequencer;

  logic clk = 1'b0;
  logic rst_n, ena, start, abort;
  logic busy, done;
  logic [2:0] state_dbg;
  int checks = 0;
  int errors = 0;

  crypt_sequencer_if sio ();

  crypt_sequencer #(.MSG_SIZE(64), .KEY_SIZE(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .abort     (abort),
    .sio       (sio),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] MSG_A = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT_A  = 64'hAD8FE9CB25076143;

  // Drives one session from IDLE. Cycle 1 is the cycle start is sampled in.
  task automatic run_session(input logic [7:0] k, input logic [63:0] m,
                             input bit stall, input int ena_off_at,
                             input int abort_at, input int stop_bits,
                             input int restart_at,
                             output logic [63:0] got, output int done_cyc,
                             output int nbits, output int stab_err,
                             output int ena_viol);
    int  kb, mb, ena_cnt;
    bit  fin, rdy, prev_stall;
    logic prev_sout;
    kb = 0; mb = 0; ena_cnt = 0; fin = 0; rdy = 1; prev_stall = 0;
    prev_sout = 0; got = '0; done_cyc = -1; nbits = 0; stab_err = 0;
    ena_viol = 0;
    sio.sin_valid = 1'b1;
    for (int t = 0; t < 600 && !fin; t++) begin
      @(negedge clk);
      start = (t == 0) || (t + 1 == restart_at);
      if (ena_off_at >= 0 && mb == ena_off_at && ena_cnt < 10 && state_dbg == 3'd2) begin
        ena = 1'b0; ena_cnt++;
      end else ena = 1'b1;
      #1;
      if (!ena && (state_dbg !== 3'd2 || sio.sin_ready !== 1'b0)) ena_viol++;
      if (done === 1'b1) begin
        done_cyc = t + 1; fin = 1;
      end else if (abort_at >= 0 && state_dbg == 3'd2 && mb == abort_at) begin
        abort = 1'b1; fin = 1;
      end else begin
        if (sio.sin_ready) begin
          if (state_dbg == 3'd1) begin sio.sin = k[7-kb]; kb++; end
          else begin sio.sin = m[63-mb]; mb++; end
        end
        if (sio.sout_valid) begin
          if (prev_stall && sio.sout !== prev_sout) stab_err++;
          rdy = stall ? ~rdy : 1'b1;
          sio.sout_ready = rdy;
          if (rdy) begin got = {got[62:0], sio.sout}; nbits++; end
          prev_sout = sio.sout; prev_stall = ~rdy;
          if (stop_bits >= 0 && nbits == stop_bits) fin = 1;
        end else sio.sout_ready = 1'b1;
      end
    end
    start = 1'b0; ena = 1'b1;
    if (stop_bits < 0) sio.sout_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0;
    sio.sin = 1'b0; sio.sin_valid = 1'b0; sio.sout_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({sio.sin_ready, sio.sout, sio.sout_valid, busy, done} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs got=%b want=00000",
        {sio.sin_ready, sio.sout, sio.sout_valid, busy, done}); end
    checks++; if (state_dbg !== 3'd0) begin
      errors++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (state_dbg !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle state=%0d busy=%b want 0/0", state_dbg, busy); end
  endtask

  task automatic test_basic;
    logic [63:0] got; int dc, nb, se, ev;
    run_session(8'hAC, MSG_A, 0, -1, -1, -1, -1, got, dc, nb, se, ev);
    checks++; if (got !== CT_A) begin
      errors++; $display("FAIL basic_stream got=%h want=%h", got, CT_A); end
    checks++; if (dc !== 139) begin
      errors++; $display("FAIL basic_done_cycle got=%0d want=139", dc); end
    checks++; if (nb !== 64) begin
      errors++; $display("FAIL basic_nbits got=%0d want=64", nb); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL basic_after_done busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_stall;
    logic [63:0] got; int dc, nb, se, ev;
    run_session(8'hAC, MSG_A, 1, -1, -1, -1, -1, got, dc, nb, se, ev);
    checks++; if (got !== CT_A) begin
      errors++; $display("FAIL stall_stream got=%h want=%h", got, CT_A); end
    checks++; if (dc !== 203) begin
      errors++; $display("FAIL stall_done_cycle got=%0d want=203", dc); end
    checks++; if (se !== 0) begin
      errors++; $display("FAIL stall_stability got=%0d unstable want=0", se); end
  endtask

  task automatic test_abort;
    logic [63:0] got; int dc, nb, se, ev, seen;
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); #1;
    checks++; if (state_dbg !== 3'd0) begin
      errors++; $display("FAIL idle_start_abort state=%0d want=0", state_dbg); end
    start = 1'b0; abort = 1'b0;
    run_session(8'hAC, MSG_A, 0, -1, 30, -1, -1, got, dc, nb, se, ev);
    @(posedge clk); #1;
    checks++; if (state_dbg !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_idle state=%0d busy=%b want 0/0", state_dbg, busy); end
    abort = 1'b0; seen = 0;
    repeat (20) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) seen++; end
    checks++; if (seen !== 0) begin
      errors++; $display("FAIL abort_no_done got=%0d active cycles want=0", seen); end
    run_session(8'h00, 64'hFFFFFFFFFFFFFFFF, 0, -1, -1, -1, -1, got, dc, nb, se, ev);
    checks++; if (got !== 64'hFFFFFFFFFFFFFFFF) begin
      errors++; $display("FAIL abort_resume_stream got=%h want=ffffffffffffffff", got); end
    checks++; if (dc !== 139) begin
      errors++; $display("FAIL abort_resume_done got=%0d want=139", dc); end
  endtask

  task automatic test_ena;
    logic [63:0] got; int dc, nb, se, ev;
    run_session(8'hAC, MSG_A, 0, 20, -1, -1, -1, got, dc, nb, se, ev);
    checks++; if (ev !== 0) begin
      errors++; $display("FAIL ena_freeze got=%0d bad cycles want=0", ev); end
    checks++; if (got !== CT_A) begin
      errors++; $display("FAIL ena_stream got=%h want=%h", got, CT_A); end
    checks++; if (dc !== 149) begin
      errors++; $display("FAIL ena_done_cycle got=%0d want=149", dc); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] got; int dc, nb, se, ev;
    run_session(8'hAC, MSG_A, 0, -1, -1, 10, -1, got, dc, nb, se, ev);
    checks++; if (state_dbg !== 3'd4) begin
      errors++; $display("FAIL mid_in_send state=%0d want=4", state_dbg); end
    rst_n = 1'b0; #1;
    checks++; if ({sio.sin_ready, sio.sout, sio.sout_valid, busy, done, state_dbg} !== 8'b0) begin
      errors++; $display("FAIL mid_reset_outputs got=%b want=0",
        {sio.sin_ready, sio.sout, sio.sout_valid, busy, done, state_dbg}); end
    sio.sout_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (state_dbg !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_release_idle state=%0d busy=%b want 0/0", state_dbg, busy); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] got; int dc, nb, se, ev, seen;
    run_session(8'hAC, MSG_A, 0, -1, -1, -1, 50, got, dc, nb, se, ev);
    checks++; if (got !== CT_A || dc !== 139) begin
      errors++; $display("FAIL busy_start_session got=%h/%0d want=%h/139", got, dc, CT_A); end
    seen = 0;
    repeat (30) begin @(negedge clk); if (busy === 1'b1) seen++; end
    checks++; if (seen !== 0) begin
      errors++; $display("FAIL busy_start_ignored got=%0d busy cycles want=0", seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_abort();
    test_ena();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crypt_sequencer.md
CRYPT_SEQUENCER -- requirements
Module: crypt_sequencer

Interface
REQ-001 SHALL have parameter MSG_SIZE, default 64: message/ciphertext length in bits; multiple of KEY_SIZE.
REQ-002 SHALL have parameter KEY_SIZE, default 8: key length in bits.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ena  input  1  global enable; low freezes all state.
REQ-006 SHALL have port start  input  1  level sampled in IDLE; begins a session.
REQ-007 SHALL have port abort  input  1  synchronous session cancel.
REQ-008 SHALL have port sin  input  1  serial key/message data bit, MSB first.
REQ-009 SHALL have port sin_valid  input  1  sin carries a valid bit.
REQ-010 SHALL have port sin_ready  output  1  block accepts sin this cycle.
REQ-011 SHALL have port sout  output  1  serial ciphertext bit, MSB first.
REQ-012 SHALL have port sout_valid  output  1  sout carries a valid bit.
REQ-013 SHALL have port sout_ready  input  1  downstream accepts sout.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at session end.
REQ-016 SHALL have port state_dbg  output  3  current state encoding.

Function
REQ-017 SHALL implement states IDLE=0, LOAD_KEY=1, LOAD_MSG=2, ENCRYPT=3, SEND=4, DONE=5.
REQ-018 IDLE: start=1 -> LOAD_KEY next cycle; bit counter cleared.
REQ-019 A bit transfer on sin SHALL occur only on cycles where sin_valid and sin_ready are both high; sin_ready high only in LOAD_KEY and LOAD_MSG.
REQ-020 LOAD_KEY: shift sin into key register MSB first; after KEY_SIZE transfers -> LOAD_MSG, counter cleared.
REQ-021 LOAD_MSG: shift sin into message register MSB first; after MSG_SIZE transfers -> ENCRYPT.
REQ-022 ENCRYPT: exactly one cycle; ciphertext bit i = msg[i] XOR key[i mod KEY_SIZE]; -> SEND.
REQ-023 SEND: sout_valid=1, sout=current ciphertext MSB; bit advances only when sout_ready=1; sout and sout_valid held stable while sout_ready=0.
REQ-024 After MSG_SIZE-th accepted output bit -> DONE; DONE asserts done for one cycle -> IDLE.
REQ-025 Minimum session latency with continuous valid/ready: 1+KEY_SIZE+MSG_SIZE+1+MSG_SIZE+1 cycles (139 at defaults).
REQ-026 Bit counter width SHALL be $clog2(MSG_SIZE)+1; no wrap within a session.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort=1 in any non-IDLE state -> IDLE next cycle, counters cleared, no done pulse; abort has priority over all transfers that cycle.
REQ-029 abort and start both high in IDLE: remain IDLE.
REQ-030 ena=0: state, counters and registers hold; sin_ready and sout_valid forced 0; done suppressed.
REQ-031 Key and message registers SHALL retain contents after DONE until overwritten by the next session.

Reset
REQ-032 rst_n low: state IDLE, counters 0, key/message/ciphertext registers 0.
REQ-033 During reset: sin_ready=0, sout=0, sout_valid=0, busy=0, done=0, state_dbg=0.
REQ-034 Reset mid-session SHALL discard all partial data; first cycle after release is IDLE.

Structure
REQ-035 A shared package crypt_pkg SHALL hold the state enum typedef and default MSG_SIZE/KEY_SIZE constants.
REQ-036 One sub-module crypt_bit_counter (clear, increment, terminal-count compare) SHALL be instantiated for input and output bit counting.

Verification
REQ-037 Key 0xAC, message 0x0123456789ABCDEF, continuous valid/ready -> sout stream 0xAD8FE9CB25076143, done at cycle 139 after start.
REQ-038 Same stimulus, sout_ready toggled 1/0 each cycle -> identical stream, sout stable during stalls, done at cycle 203.
REQ-039 abort asserted after 30 message bits -> IDLE next cycle, busy=0, no done; new session with key 0x00, message 0xFFFF...FF -> 0xFFFFFFFFFFFFFFFF out.
REQ-040 ena=0 for 10 cycles during LOAD_MSG -> state_dbg holds 2, sin_ready=0, final ciphertext unchanged vs REQ-037.
REQ-041 rst_n pulsed low during SEND -> all outputs 0 immediately, IDLE after release; start pulse during busy ignored (no second session).
